// File: rtl/nth_root_pkg.sv
// rtl/nth_root_pkg.sv - shared state type, width helpers and defaults for the n-th root engine
package nth_root_pkg;

  localparam int DEF_INT_W   = 10;
  localparam int DEF_FRAC_W  = 10;
  localparam int DEF_EXP_W   = 3;
  localparam int DEF_EXP_MAX = 7;

  typedef enum logic [1:0] {
    S_IDLE,
    S_POW,
    S_CMP,
    S_DONE
  } state_t;

  function automatic int calc_out_w(input int int_w, input int frac_w);
    return int_w + frac_w;
  endfunction

  // Wide enough that cand^n never wraps for any legal exponent.
  function automatic int calc_p_w(input int exp_max, input int out_w);
    return exp_max * out_w;
  endfunction

endpackage

// File: rtl/root_pow_unit.sv
// rtl/root_pow_unit.sv - iterative power unit: prod = cand^n, one multiply per step
module root_pow_unit #(
  parameter int OUT_W = 20,
  parameter int P_W   = 140,
  parameter int EXP_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_step,
  input  logic [EXP_W-1:0] i_n,
  input  logic [OUT_W-1:0] i_cand,
  output logic [P_W-1:0]   o_prod,
  output logic             o_last_step
);

  logic [P_W-1:0]   r_prod;
  logic [EXP_W-1:0] r_cnt;
  logic [P_W-1:0]   w_cand_ext;
  logic [P_W-1:0]   w_mul;

  assign w_cand_ext = P_W'(i_cand);
  assign w_mul      = r_prod * w_cand_ext;

  // r_cnt holds the number of multiplies still owed for the current candidate.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prod <= '0;
      r_cnt  <= '0;
    end else if (i_load) begin
      r_prod <= w_cand_ext;
      r_cnt  <= i_n - EXP_W'(1);
    end else if (i_step) begin
      r_prod <= w_mul;
      r_cnt  <= r_cnt - EXP_W'(1);
    end
  end

  assign o_prod      = r_prod;
  assign o_last_step = (r_cnt == EXP_W'(1));

endmodule

// File: rtl/nth_root_seq.sv
// rtl/nth_root_seq.sv - sequential floor n-th root engine, MSB-first bit search
// with exact power comparison and valid/ready handshakes on both sides.
module nth_root_seq
  import nth_root_pkg::*;
#(
  parameter int INT_W   = DEF_INT_W,
  parameter int FRAC_W  = DEF_FRAC_W,
  parameter int EXP_W   = DEF_EXP_W,
  parameter int EXP_MAX = DEF_EXP_MAX
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [INT_W-1:0]         in_radicand,
  input  logic [EXP_W-1:0]         in_exp,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [INT_W+FRAC_W-1:0]  out_root,
  output logic                     out_exact,
  output logic                     out_err
);

  localparam int OUT_W = calc_out_w(INT_W, FRAC_W);
  localparam int P_W   = calc_p_w(EXP_MAX, OUT_W);
  localparam int BIT_W = $clog2(OUT_W);
  localparam logic [BIT_W-1:0] BIT_TOP   = BIT_W'(OUT_W - 1);
  localparam logic [EXP_W-1:0] EXP_MAX_V = EXP_W'(EXP_MAX);

  state_t             r_state;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [OUT_W-1:0]   r_root;
  logic               r_exact;
  logic               r_err;
  logic [BIT_W-1:0]   r_bit;
  logic [INT_W-1:0]   r_rad;
  logic [EXP_W-1:0]   r_n;

  logic               w_accept;
  logic               w_bad_exp;
  logic               w_start_ok;
  logic [OUT_W-1:0]   w_cur_cand;
  logic [OUT_W-1:0]   w_next_mask;
  logic [P_W-1:0]     w_prod;
  logic [P_W-1:0]     w_target;
  logic               w_hit;
  logic               w_eq;
  logic [OUT_W-1:0]   w_root_upd;
  logic               w_load;
  logic [OUT_W-1:0]   w_load_cand;
  logic [OUT_W-1:0]   w_pow_cand;
  logic [EXP_W-1:0]   w_pow_n;
  logic               w_last_step;
  logic               w_cmp_more;

  assign w_accept   = (r_state == S_IDLE) && in_valid;
  assign w_bad_exp  = (in_exp == '0) || (in_exp > EXP_MAX_V);
  assign w_start_ok = !w_bad_exp && (in_radicand != '0);

  assign w_cur_cand  = r_root | (OUT_W'(1) << r_bit);
  assign w_next_mask = OUT_W'(1) << (r_bit - BIT_W'(1));

  // Scaling the radicand by 2^(n*FRAC_W) keeps the compare in pure integers.
  assign w_target   = P_W'(r_rad) << (int'(r_n) * FRAC_W);
  assign w_hit      = (w_prod <= w_target);
  assign w_eq       = (w_prod == w_target);
  assign w_root_upd = w_hit ? w_cur_cand : r_root;
  assign w_cmp_more = !w_eq && (r_bit != '0);

  assign w_load      = (w_accept && w_start_ok) || ((r_state == S_CMP) && w_cmp_more);
  assign w_load_cand = (r_state == S_IDLE) ? (OUT_W'(1) << BIT_TOP) : (w_root_upd | w_next_mask);
  assign w_pow_cand  = w_load ? w_load_cand : w_cur_cand;
  assign w_pow_n     = (r_state == S_IDLE) ? in_exp : r_n;

  root_pow_unit #(
    .OUT_W (OUT_W),
    .P_W   (P_W),
    .EXP_W (EXP_W)
  ) u_pow (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_load),
    .i_step      (r_state == S_POW),
    .i_n         (w_pow_n),
    .i_cand      (w_pow_cand),
    .o_prod      (w_prod),
    .o_last_step (w_last_step)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_root      <= '0;
      r_exact     <= 1'b0;
      r_err       <= 1'b0;
      r_bit       <= BIT_TOP;
      r_rad       <= '0;
      r_n         <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_rad      <= in_radicand;
            r_n        <= in_exp;
            r_root     <= '0;
            r_bit      <= BIT_TOP;
            r_exact    <= 1'b0;
            r_err      <= 1'b0;
            r_in_ready <= 1'b0;
            if (w_bad_exp) begin
              r_err   <= 1'b1;
              r_state <= S_DONE;
            end else if (in_radicand == '0) begin
              r_exact <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_state <= (in_exp > EXP_W'(1)) ? S_POW : S_CMP;
            end
          end
        end
        S_POW: begin
          if (w_last_step) r_state <= S_CMP;
        end
        S_CMP: begin
          r_root <= w_root_upd;
          if (w_eq) begin
            r_exact     <= 1'b1;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else if (r_bit == '0) begin
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_bit   <= r_bit - BIT_W'(1);
            r_state <= (r_n > EXP_W'(1)) ? S_POW : S_CMP;
          end
        end
        S_DONE: begin
          // Early-exit paths arrive here with out_valid still low; raise it one edge later.
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_root  = r_root;
  assign out_exact = r_exact;
  assign out_err   = r_err;

endmodule

// File: doc/nth_root_seq.md
Name: nth_root_seq

Overview:
- Parametrised sequential n-th root engine: takes an unsigned integer radicand and an exponent n, and returns floor(radicand^(1/n)) as an unsigned fixed-point value.
- Generalises the team's fixed Q10.10 root unit with:
  - configurable integer/fraction widths and maximum exponent;
  - exact (non-truncating) power comparison;
  - valid/ready handshakes on both sides;
  - exact-match and error flags.
- Sits behind the arithmetic command front end as a multi-cycle slave; one operation in flight.

Parameters:
- INT_W, 10, radicand width and root integer bits.
- FRAC_W, 10, root fraction bits.
- EXP_W, 3, exponent port width.
- EXP_MAX, 7, largest legal exponent (1 <= EXP_MAX <= 2^EXP_W-1).
- Derived (localparam): OUT_W = INT_W+FRAC_W; P_W = EXP_MAX*OUT_W (power/compare width).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  engine idle, request accepted when in_valid&in_ready.
- in_radicand  in  INT_W  unsigned integer radicand.
- in_exp  in  EXP_W  exponent n.
- out_valid  out  1  result valid, held until taken.
- out_ready  in  1  consumer accepts result.
- out_root  out  OUT_W  root, unsigned Q(INT_W).(FRAC_W), floor-rounded.
- out_exact  out  1  root^n equals radicand exactly.
- out_err  out  1  illegal exponent.

Behaviour:
- Reset (clk edge with rst=1): state IDLE; in_ready=1, out_valid=0, out_root=0, out_exact=0, out_err=0. Applies mid-operation: any in-flight operation is aborted with no output.
- States:
  - IDLE: in_ready=1. On accept, latch radicand and n; set root=0, bit=OUT_W-1.
    - n==0 or n>EXP_MAX -> DONE with err=1, root=0, exact=0.
    - radicand==0 -> DONE with root=0, exact=1.
    - otherwise cand=root|(1<<bit) and prod<=cand, then POW if n>1, else CMP.
  - POW: prod<=prod*cand, exact, P_W bits. Stays n-1 cycles total, counted by a step counter; then CMP.
  - CMP: target = radicand<<(n*FRAC_W), zero-extended to P_W.
    - prod<target: root|=1<<bit.
    - prod==target: root|=1<<bit, exact=1, -> DONE.
    - prod>target: root unchanged.
    - Then, if bit==0 -> DONE; else bit--, reload prod with the new cand, -> POW or CMP as above.
  - DONE: out_valid=1, in_ready=0. out_root/out_exact/out_err stable while out_valid&!out_ready. On out_ready -> IDLE; out_valid drops next cycle.
- Latency: each bit costs exactly n cycles (n-1 POW + 1 CMP). out_valid rises k*n edges after the accept edge, where k = number of bits evaluated: OUT_W normally, fewer on exact match.
  - Error case and radicand==0 case: out_valid rises 1 edge after accept.
- in_ready is low from the accept edge until the DONE->IDLE edge. A new in_valid during DONE waits; it is accepted no earlier than the cycle after the output handshake.
- Inputs are sampled only at accept; later changes are ignored.
- Products never truncate: cand < 2^OUT_W and n <= EXP_MAX, so cand^n < 2^P_W.
- Result bits are computed MSB first; root is monotone non-decreasing during the operation.

Decomposition:
- Package nth_root_pkg:
  - state enum (IDLE, POW, CMP, DONE);
  - width helper functions for OUT_W and P_W;
  - default parameter constants.
- Sub-module root_pow_unit holds prod, the step counter, and the single P_W x OUT_W multiplier.
  - Inputs: load, step, cand.
  - Outputs: prod, last_step.
- nth_root_seq keeps the FSM, bit index, root accumulator, compare and handshakes.

Test Plan:
- radicand=8, n=3, out_ready=1 -> out_root=0x00800 (2.0), out_exact=1, out_err=0; out_valid 27 edges after accept (9 bits x 3).
- radicand=2, n=2 -> out_root=0x005A8 (1448/1024), out_exact=0; out_valid 40 edges after accept.
- radicand=1023, n=1 -> out_root=0xFFC00, out_exact=1, 10 edges. radicand=1023, n=7 -> out_root = floor(1023^(1/7)*1024) per golden model, 140 edges.
- n=0 -> out_err=1, out_root=0, 1 edge. radicand=0, n=5 -> out_root=0, out_exact=1, 1 edge.
- out_ready held low 5 cycles in DONE -> outputs stable, in_ready=0, queued in_valid not accepted until the cycle after the handshake; back-to-back random ops match the golden model.
- rst pulsed mid-POW -> next cycle in_ready=1, out_valid=0, out_root=0; a following op returns the correct result.
